// File: rtl/spram_stream_tx.sv
// SPRAM frame-buffer reader: fetches len bytes from base_addr and streams them out as an SPI mode-0 master.
// Compile-time option: define LSB_FIRST_EN to shift each byte out bit0 first (default is MSB first).
module spram_stream_tx #(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 14,
    parameter int DIV    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              sck_out,
    output logic              cs_n,
    output logic              sdo,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        LOW    = 3'd3,
        HIGH   = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [LEN_W-1:0]    remaining_reg, remaining_next;
    logic [2:0]          bitcnt_reg, bitcnt_next;
    logic [DW-1:0]       div_reg, div_next;
    logic [7:0]          shift_reg, shift_next;
    logic [7:0]          hold_reg, hold_next;
    logic                rd_valid_reg;

    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic                mem_re_reg, mem_re_next;
    logic                sck_reg, sck_next;
    logic                cs_n_reg, cs_n_next;
    logic                sdo_reg, sdo_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    logic                accept;
    logic                phase_end;
    logic                last_bit;
    logic                more;
    logic                prefetch;
    logic [7:0]          byte_in;
    logic [7:0]          byte_ordered;

    assign accept    = (state_reg == IDLE) && start && !busy_reg;
    assign phase_end = (div_reg == DIV_LAST);
    assign last_bit  = (bitcnt_reg == 3'd0);
    assign more      = (remaining_reg > LEN_W'(1));

    // Read data is only guaranteed for the cycle after mem_re; hold it for longer HIGH phases.
    assign byte_in   = rd_valid_reg ? mem_rdata : hold_reg;

    // The shifter always sends bit 7 first; LSB-first mode reverses the byte on the way in.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_order
`ifdef LSB_FIRST_EN
            assign byte_ordered[gi] = byte_in[7-gi];
`else
            assign byte_ordered[gi] = byte_in[gi];
`endif
        end
    endgenerate

    // With DIV=1 the HIGH phase is one cycle, too short for a read issued inside it,
    // so the prefetch moves to the start of the final LOW phase.
    generate
        if (DIV > 1) begin : g_pf_high
            assign prefetch = (state_reg == LOW) && phase_end && last_bit && more;
        end else begin : g_pf_low
            assign prefetch = (state_reg == HIGH) && phase_end && (bitcnt_reg == 3'd1) && more;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (len == '0) ? FINISH : FETCH;
                end
            end
            FETCH:  state_next = LOAD;
            LOAD:   state_next = LOW;
            LOW: begin
                if (phase_end) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    state_next = (!last_bit || more) ? LOW : FINISH;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        bitcnt_next    = bitcnt_reg;
        shift_next     = shift_reg;
        hold_next      = rd_valid_reg ? mem_rdata : hold_reg;
        mem_addr_next  = mem_addr_reg;
        mem_re_next    = 1'b0;
        sdo_next       = sdo_reg;
        sck_next       = (state_next == HIGH);
        cs_n_next      = !((state_next == LOW) || (state_next == HIGH));
        busy_next      = accept || (state_reg != IDLE);
        done_next      = (state_reg == FINISH);

        if (((state_reg == LOW) || (state_reg == HIGH)) && (state_next == state_reg)) begin
            div_next = div_reg + 1'b1;
        end else begin
            div_next = '0;
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    addr_next      = base_addr;
                    remaining_next = len;
                    if (len != '0) begin
                        mem_re_next   = 1'b1;
                        mem_addr_next = base_addr;
                    end
                end
            end
            LOAD: begin
                shift_next  = byte_ordered;
                sdo_next    = byte_ordered[7];
                bitcnt_next = 3'd7;
                addr_next   = addr_reg + 1'b1;
            end
            HIGH: begin
                if (phase_end) begin
                    if (!last_bit) begin
                        shift_next  = {shift_reg[6:0], 1'b0};
                        sdo_next    = shift_reg[6];
                        bitcnt_next = bitcnt_reg - 3'd1;
                    end else if (more) begin
                        shift_next     = byte_ordered;
                        sdo_next       = byte_ordered[7];
                        bitcnt_next    = 3'd7;
                        remaining_next = remaining_reg - 1'b1;
                    end else begin
                        sdo_next = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        if (prefetch) begin
            mem_re_next   = 1'b1;
            mem_addr_next = addr_reg;
            addr_next     = addr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
            bitcnt_reg    <= '0;
            div_reg       <= '0;
            shift_reg     <= '0;
            hold_reg      <= '0;
            rd_valid_reg  <= 1'b0;
            mem_addr_reg  <= '0;
            mem_re_reg    <= 1'b0;
            sck_reg       <= 1'b0;
            cs_n_reg      <= 1'b1;
            sdo_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            bitcnt_reg    <= bitcnt_next;
            div_reg       <= div_next;
            shift_reg     <= shift_next;
            hold_reg      <= hold_next;
            rd_valid_reg  <= mem_re_reg;
            mem_addr_reg  <= mem_addr_next;
            mem_re_reg    <= mem_re_next;
            sck_reg       <= sck_next;
            cs_n_reg      <= cs_n_next;
            sdo_reg       <= sdo_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign mem_addr = mem_addr_reg;
    assign mem_re   = mem_re_reg;
    assign sck_out  = sck_reg;
    assign cs_n     = cs_n_reg;
    assign sdo      = sdo_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_spram_stream_tx.sv
// Directed bench for spram_stream_tx: RAM model, negedge monitor, one task per scenario.
module tb_spram_stream_tx;

    localparam int ADDR_W = 14;
    localparam int LEN_W  = 14;
    localparam int DIV    = 2;

`ifdef LSB_FIRST_EN
    localparam logic [23:0] EXP_GAP = 24'b10000000_11111111_00000001;
`else
    localparam logic [23:0] EXP_GAP = 24'b00000001_11111111_10000000;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [7:0]        mem_rdata = 8'h00;
    logic              sck_out, cs_n, sdo, busy, done;

    logic [7:0] ram [0:16383];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    spram_stream_tx #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DIV(DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .sck_out(sck_out), .cs_n(cs_n), .sdo(sdo), .busy(busy), .done(done)
    );

    // Single-port RAM with registered read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_re === 1'b1) mem_rdata <= ram[mem_addr];
    end

    // Event monitor: appends only, scenario tasks look at the growth since they began.
    logic              sdo_q[$];
    int                rise_q[$];
    int                csfall_q[$];
    int                done_q[$];
    int                bfall_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int                cs_low_cnt = 0;
    logic              prev_sck = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (sck_out === 1'b1 && prev_sck === 1'b0) begin
            sdo_q.push_back(sdo);
            rise_q.push_back(cyc);
        end
        if (cs_n === 1'b0) cs_low_cnt <= cs_low_cnt + 1;
        if (cs_n === 1'b0 && prev_cs === 1'b1) csfall_q.push_back(cyc);
        if (done === 1'b1) done_q.push_back(cyc);
        if (busy === 1'b0 && prev_busy === 1'b1) bfall_q.push_back(cyc);
        if (mem_re === 1'b1) addr_q.push_back(mem_addr);
        prev_sck  <= sck_out;
        prev_cs   <= cs_n;
        prev_busy <= busy;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [23:0] stream(input int r0, input int n);
        logic [23:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[22:0], (r0 + i < sdo_q.size()) ? sdo_q[r0 + i] : 1'b0};
        end
        return v;
    endfunction

    task automatic run_xfer(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l, output int sc);
        int d0;
        step();
        base_addr = b;
        len = l;
        start = 1'b1;
        sc = cyc;
        d0 = done_q.size();
        step();
        start = 1'b0;
        for (int i = 0; i < 2000 && !(done_q.size() > d0 && busy === 1'b0); i++) step();
        n_cmp++;
        if (!(done_q.size() > d0 && busy === 1'b0)) begin
            n_fail++;
            $display("FAIL xfer_timeout: base=%h len=%0d done_seen=%0d busy=%b required done then busy=0",
                     b, l, done_q.size() - d0, busy);
        end
        $display("xfer base=%h len=%0d start_cyc=%0d rises_total=%0d", b, l, sc, rise_q.size());
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        n_cmp++; if (sck_out !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b required 0", sck_out); end
        n_cmp++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b required 1", cs_n); end
        n_cmp++; if (sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b required 0", sdo); end
        n_cmp++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL reset_mem_re: got %b required 0", mem_re); end
        n_cmp++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_byte();
        int sc, r0, c0, f0, d0, b0, a0, v;
        r0 = sdo_q.size(); c0 = cs_low_cnt; f0 = csfall_q.size();
        d0 = done_q.size(); b0 = bfall_q.size(); a0 = addr_q.size();
        run_xfer(14'h0000, 14'd1, sc);
        n_cmp++; if (sdo_q.size() - r0 != 8) begin n_fail++; $display("FAIL single_rises: got %0d required 8", sdo_q.size() - r0); end
        n_cmp++; if (stream(r0, 8) !== 24'h0000A5) begin n_fail++; $display("FAIL single_bits: got %h required a5", stream(r0, 8)); end
        n_cmp++; if (cs_low_cnt - c0 != 32) begin n_fail++; $display("FAIL single_cs_low: got %0d required 32", cs_low_cnt - c0); end
        n_cmp++; if (done_q.size() - d0 != 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d required 1", done_q.size() - d0); end
        v = (csfall_q.size() > f0) ? csfall_q[f0] - sc : -1;
        n_cmp++; if (v != 3) begin n_fail++; $display("FAIL single_cs_latency: got %0d required 3", v); end
        v = (done_q.size() > d0) ? done_q[d0] - sc : -1;
        n_cmp++; if (v != 36) begin n_fail++; $display("FAIL single_done_cyc: got %0d required 36", v); end
        v = (bfall_q.size() > b0) ? bfall_q[b0] - sc : -1;
        n_cmp++; if (v != 37) begin n_fail++; $display("FAIL single_busy_fall: got %0d required 37", v); end
        n_cmp++; if (addr_q.size() - a0 != 1) begin n_fail++; $display("FAIL single_re_cnt: got %0d required 1", addr_q.size() - a0); end
    endtask

    task automatic test_gapless();
        int sc, r0, c0, f0, a0, stalls;
        logic [ADDR_W-1:0] exp_a [3];
        exp_a[0] = 14'h0010; exp_a[1] = 14'h0011; exp_a[2] = 14'h0012;
        r0 = sdo_q.size(); c0 = cs_low_cnt; f0 = csfall_q.size(); a0 = addr_q.size();
        run_xfer(14'h0010, 14'd3, sc);
        stalls = 0;
        for (int i = r0 + 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 2 * DIV) stalls++;
        n_cmp++; if (sdo_q.size() - r0 != 24) begin n_fail++; $display("FAIL gap_rises: got %0d required 24", sdo_q.size() - r0); end
        n_cmp++; if (stalls != 0) begin n_fail++; $display("FAIL gap_stalls: got %0d required 0", stalls); end
        n_cmp++; if (stream(r0, 24) !== EXP_GAP) begin n_fail++; $display("FAIL gap_bits: got %b required %b", stream(r0, 24), EXP_GAP); end
        n_cmp++; if (cs_low_cnt - c0 != 96) begin n_fail++; $display("FAIL gap_cs_low: got %0d required 96", cs_low_cnt - c0); end
        n_cmp++; if (csfall_q.size() - f0 != 1) begin n_fail++; $display("FAIL gap_cs_falls: got %0d required 1", csfall_q.size() - f0); end
        n_cmp++; if (addr_q.size() - a0 != 3) begin n_fail++; $display("FAIL gap_re_cnt: got %0d required 3", addr_q.size() - a0); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (addr_q.size() <= a0 + i || addr_q[a0 + i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL gap_addr%0d: got %h required %h", i,
                         (addr_q.size() > a0 + i) ? addr_q[a0 + i] : 14'h3fff ^ exp_a[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int sc, r0, a0;
        r0 = sdo_q.size(); a0 = addr_q.size();
        run_xfer(14'h3FFF, 14'd2, sc);
        n_cmp++; if (stream(r0, 16) !== 24'h003CC3) begin n_fail++; $display("FAIL wrap_bits: got %h required 3cc3", stream(r0, 16)); end
        n_cmp++; if (addr_q.size() - a0 != 2) begin n_fail++; $display("FAIL wrap_re_cnt: got %0d required 2", addr_q.size() - a0); end
        n_cmp++; if (addr_q.size() < a0 + 2 || addr_q[a0] !== 14'h3FFF || addr_q[a0 + 1] !== 14'h0000) begin
            n_fail++; $display("FAIL wrap_addrs: first/second read address wrong, required 3fff then 0000");
        end
    endtask

    task automatic test_len_zero();
        int sc, r0, c0, a0, d0, b0, v;
        r0 = sdo_q.size(); c0 = cs_low_cnt; a0 = addr_q.size(); d0 = done_q.size(); b0 = bfall_q.size();
        run_xfer(14'h0005, 14'd0, sc);
        v = (done_q.size() > d0) ? done_q[d0] - sc : -1;
        n_cmp++; if (v != 2) begin n_fail++; $display("FAIL zero_done_cyc: got %0d required 2", v); end
        v = (bfall_q.size() > b0) ? bfall_q[b0] - sc : -1;
        n_cmp++; if (v != 3) begin n_fail++; $display("FAIL zero_busy_fall: got %0d required 3", v); end
        n_cmp++; if (cs_low_cnt - c0 != 0) begin n_fail++; $display("FAIL zero_cs_low: got %0d required 0", cs_low_cnt - c0); end
        n_cmp++; if (sdo_q.size() - r0 != 0) begin n_fail++; $display("FAIL zero_rises: got %0d required 0", sdo_q.size() - r0); end
        n_cmp++; if (addr_q.size() - a0 != 0) begin n_fail++; $display("FAIL zero_re_cnt: got %0d required 0", addr_q.size() - a0); end
    endtask

    task automatic test_start_while_busy();
        int r0, a0, d0;
        r0 = sdo_q.size(); a0 = addr_q.size(); d0 = done_q.size();
        step();
        base_addr = 14'h0000; len = 14'd1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        base_addr = 14'h0010; len = 14'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2000 && !(done_q.size() > d0 && busy === 1'b0); i++) step();
        repeat (150) step();
        $display("xfer base=0000 len=1 with ignored restart rises=%0d", sdo_q.size() - r0);
        n_cmp++; if (sdo_q.size() - r0 != 8) begin n_fail++; $display("FAIL busy_rises: got %0d required 8", sdo_q.size() - r0); end
        n_cmp++; if (addr_q.size() - a0 != 1) begin n_fail++; $display("FAIL busy_re_cnt: got %0d required 1", addr_q.size() - a0); end
        n_cmp++; if (done_q.size() - d0 != 1) begin n_fail++; $display("FAIL busy_done_cnt: got %0d required 1", done_q.size() - d0); end
    endtask

    task automatic test_reset_mid_byte();
        int r0, d0;
        r0 = sdo_q.size(); d0 = done_q.size();
        step();
        base_addr = 14'h0010; len = 14'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 200 && (sdo_q.size() - r0) < 4; i++) step();
        n_cmp++; if (sdo_q.size() - r0 < 4) begin n_fail++; $display("FAIL rst_reach_rise4: got %0d rises required 4", sdo_q.size() - r0); end
        reset = 1'b0;
        step();
        n_cmp++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: got %b required 1", cs_n); end
        n_cmp++; if (sck_out !== 1'b0) begin n_fail++; $display("FAIL rst_sck: got %b required 0", sck_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        reset = 1'b1;
        repeat (20) step();
        $display("xfer base=0010 len=3 aborted by reset after %0d rises", sdo_q.size() - r0);
        n_cmp++; if (done_q.size() != d0) begin n_fail++; $display("FAIL rst_no_done: got %0d pulses required 0", done_q.size() - d0); end
        n_cmp++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_cs_idle: got %b required 1", cs_n); end
    endtask

    initial begin
        ram[14'h0000] = 8'hC3;
        ram[14'h0010] = 8'h01;
        ram[14'h0011] = 8'hFF;
        ram[14'h0012] = 8'h80;
        ram[14'h3FFF] = 8'h3C;
        test_reset();
        test_wrap();
        ram[14'h0000] = 8'hA5;
        test_single_byte();
        test_gapless();
        test_len_zero();
        test_start_while_busy();
        test_reset_mid_byte();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spram_stream_tx.md
Name: spram_stream_tx

Overview:
- Read-side counterpart of the SPI byte receiver that fills the SPRAM frame buffer.
- On a start pulse, fetches `len` consecutive bytes from the single-port RAM starting at `base_addr`.
- Serialises each byte as SPI mode 0 master: generates `sck_out`, `cs_n` and `sdo`, MSB first by default.
- Feeds the downstream serial sink (LED string driver / MCU readback) from the buffer the receiver wrote.

Parameters:
- ADDR_W, 14: RAM address width.
- LEN_W, 14: width of the byte-count input.
- DIV, 2: sck half-period in clk cycles; legal values are 1 or more.

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous active-low reset
- start  in  1  one-cycle request; sampled only when busy=0
- base_addr  in  ADDR_W  first RAM address to read
- len  in  LEN_W  number of bytes to send
- mem_addr  out  ADDR_W  RAM read address
- mem_re  out  1  RAM read strobe
- mem_rdata  in  8  RAM read data, valid 1 cycle after mem_re
- sck_out  out  1  SPI clock, idles low
- cs_n  out  1  chip select, active low
- sdo  out  1  serial data out
- busy  out  1  high from start accept until the done cycle, inclusive
- done  out  1  one-cycle pulse at end of transfer

Behaviour:
- Reset is synchronous, active-low, and has priority over everything:
  - sck_out=0, cs_n=1, sdo=0, mem_re=0, mem_addr=0, busy=0, done=0, FSM=IDLE.
  - Reset mid-transfer aborts immediately with no done pulse.
- All outputs are registered.
- FSM states: IDLE, FETCH, LOAD, LOW, HIGH, FINISH.
- IDLE:
  - On start=1: latch base_addr into the address counter, latch len into the remaining counter, set busy=1.
  - If len=0: go to FINISH.
  - Otherwise go to FETCH.
  - start while busy=1 is ignored.
- FETCH: mem_re=1 and mem_addr=address counter for 1 cycle, then go to LOAD.
- LOAD:
  - Capture mem_rdata into the shift register; bit counter=7.
  - cs_n=0; sdo=bit7 (bit0 if LSB_FIRST_EN); sck_out=0.
  - Increment the address counter.
  - cs_n therefore first goes low 3 clk edges after the start sample.
- LOW: sck_out=0 for DIV cycles, then go to HIGH; rising edge of sck_out occurs on entering HIGH.
- HIGH: sck_out=1 for DIV cycles.
  - If bit counter>0: at the end of HIGH, shift, put the next bit on sdo, decrement the bit counter, go to LOW. sdo changes only on sck falling edges.
  - If bit counter=0 and remaining>1: in the first HIGH cycle, issue mem_re with the next address (prefetch). At the end of HIGH, load mem_rdata directly into the shift register, decrement remaining, go to LOW with the new MSB on sdo. The stream is gapless: no idle sck periods between bytes and cs_n stays low.
  - If bit counter=0 and remaining=1: go to FINISH.
- FINISH:
  - cs_n=1, sck_out=0, sdo=0, done=1 for 1 cycle, busy=1 in this cycle.
  - Next cycle: busy=0, back to IDLE; a new start may be accepted that cycle.
- Arithmetic and wrap:
  - Address counter wraps modulo 2^ADDR_W (0x3FFF→0x0000 at default width).
  - Remaining counter never underflows.
- Transfer timing:
  - Per byte: 16*DIV clk cycles of cs_n low.
  - N-byte transfer: cs_n low for exactly N*16*DIV cycles.
- mem_re is asserted only in FETCH or in the prefetch cycle; never in IDLE.

Optional Feature:
- Macro: LSB_FIRST_EN
- Defined: each byte is shifted LSB first; LOAD presents bit0 and shifting is rightward.
- Undefined: MSB first. Order is fixed at compile time; there is no runtime control.

Test Plan:
- Single byte, DIV=2, RAM[0x0000]=0xA5, start with base=0, len=1:
  - sdo sampled on 8 sck rising edges = 1,0,1,0,0,1,0,1.
  - cs_n low exactly 32 cycles, one done pulse, busy drops the cycle after done.
- Gapless multi-byte, RAM[0x10..0x12]=0x01,0xFF,0x80, len=3:
  - 24 rising edges with no stalled sck.
  - Bitstream 00000001 11111111 10000000; mem_re pulses exactly 3 times at addresses 0x10, 0x11, 0x12.
- Wrap, base=0x3FFF, len=2, RAM[0x3FFF]=0x3C, RAM[0x0000]=0xC3:
  - Reads 0x3FFF then 0x0000; stream 00111100 11000011.
- len=0: done pulses 2 cycles after start; cs_n never low, sck_out never toggles, mem_re never asserted.
- Start while busy, plus reset mid-byte:
  - Second start during a transfer is ignored (no extra bytes).
  - Asserting reset=0 after the 4th rising edge gives cs_n=1, sck_out=0, busy=0 on the next edge and no done pulse.
- LSB_FIRST_EN defined, RAM byte 0xA5 → sdo sequence 1,0,1,0,0,1,0,1 in reversed bit order (bit0 first); with 0x01 the first sampled bit is 1.
